// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decode-side inputs, writeback bypass port, hazard controls and
// the registered execute-side outputs.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
);
    logic              stall_e, flush_e;
    logic              valid_d;
    logic [XLEN-1:0]   pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d;
    logic [REG_AW-1:0] rs1_d, rs2_d, rd_d;
    logic              reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d;
    logic [1:0]        result_src_d;
    logic [ALUC_W-1:0] alu_control_d;
    logic              reg_write_w;
    logic [REG_AW-1:0] rd_w;
    logic [XLEN-1:0]   result_w;
    logic              valid_e;
    logic [XLEN-1:0]   pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
    logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
    logic              reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e;
    logic [1:0]        result_src_e;
    logic [ALUC_W-1:0] alu_control_e;

    modport master (
        output stall_e, flush_e, valid_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d,
               rs1_d, rs2_d, rd_d, reg_write_d, mem_write_d, alu_src_d, branch_d,
               jump_d, result_src_d, alu_control_d, reg_write_w, rd_w, result_w,
        input  valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
               reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e,
               result_src_e, alu_control_e
    );

    modport slave (
        input  stall_e, flush_e, valid_d, pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d,
               rs1_d, rs2_d, rd_d, reg_write_d, mem_write_d, alu_src_d, branch_d,
               jump_d, result_src_d, alu_control_d, reg_write_w, rd_w, result_w,
        output valid_e, pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
               reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e,
               result_src_e, alu_control_e
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass on load, operand refresh while
// stalled, and flush-to-bubble. All outputs come straight from flops.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc, pc_plus4, rd1, rd2;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]   imm;
        logic              reg_write, mem_write, alu_src, branch, jump;
        logic [1:0]        result_src;
        logic [ALUC_W-1:0] alu_control;
    } stage_t;

    stage_t d, e;
    logic   wb_live, byp1, byp2, ref1, ref2;

    // x0 is never forwarded; a bubble's zero addresses therefore never match
    assign wb_live = bus.reg_write_w && (bus.rd_w != '0);
    assign byp1    = wb_live && (bus.rd_w == bus.rs1_d);
    assign byp2    = wb_live && (bus.rd_w == bus.rs2_d);
    assign ref1    = wb_live && (bus.rd_w == e.rs1);
    assign ref2    = wb_live && (bus.rd_w == e.rs2);

    always_comb begin
        d             = '0;
        d.valid       = bus.valid_d;
        d.pc          = bus.pc_d;
        d.pc_plus4    = bus.pc_plus4_d;
        d.rd1         = byp1 ? bus.result_w : bus.rd1_d;
        d.rd2         = byp2 ? bus.result_w : bus.rd2_d;
        d.rs1         = bus.rs1_d;
        d.rs2         = bus.rs2_d;
        d.rd          = bus.rd_d;
        d.imm         = bus.imm_d;
        d.reg_write   = bus.reg_write_d;
        d.mem_write   = bus.mem_write_d;
        d.alu_src     = bus.alu_src_d;
        d.branch      = bus.branch_d;
        d.jump        = bus.jump_d;
        d.result_src  = bus.result_src_d;
        d.alu_control = bus.alu_control_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e <= '0;
        end else if (bus.flush_e) begin
            e <= '0;
        end else if (bus.stall_e) begin
            // keep held operands coherent with writebacks that land during the stall
            if (ref1) e.rd1 <= bus.result_w;
            if (ref2) e.rd2 <= bus.result_w;
        end else begin
            e <= d;
        end
    end

    assign bus.valid_e       = e.valid;
    assign bus.pc_e          = e.pc;
    assign bus.pc_plus4_e    = e.pc_plus4;
    assign bus.rd1_e         = e.rd1;
    assign bus.rd2_e         = e.rd2;
    assign bus.rs1_e         = e.rs1;
    assign bus.rs2_e         = e.rs2;
    assign bus.rd_e          = e.rd;
    assign bus.imm_e         = e.imm;
    assign bus.reg_write_e   = e.reg_write;
    assign bus.mem_write_e   = e.mem_write;
    assign bus.alu_src_e     = e.alu_src;
    assign bus.branch_e      = e.branch;
    assign bus.jump_e        = e.jump;
    assign bus.result_src_e  = e.result_src;
    assign bus.alu_control_e = e.alu_control;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected execute slots are queued as stimulus
// is driven and popped when the stage output is sampled.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 3;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc, pc_plus4, rd1, rd2;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]   imm;
        logic              reg_write, mem_write, alu_src, branch, jump;
        logic [1:0]        result_src;
        logic [ALUC_W-1:0] alu_control;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    slot_t sb[$];
    slot_t want, got, s, held;

    id_ex_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW), .ALUC_W(ALUC_W)) bus ();
    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .ALUC_W(ALUC_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input slot_t x);
        bus.valid_d       = x.valid;
        bus.pc_d          = x.pc;
        bus.pc_plus4_d    = x.pc_plus4;
        bus.rd1_d         = x.rd1;
        bus.rd2_d         = x.rd2;
        bus.rs1_d         = x.rs1;
        bus.rs2_d         = x.rs2;
        bus.rd_d          = x.rd;
        bus.imm_d         = x.imm;
        bus.reg_write_d   = x.reg_write;
        bus.mem_write_d   = x.mem_write;
        bus.alu_src_d     = x.alu_src;
        bus.branch_d      = x.branch;
        bus.jump_d        = x.jump;
        bus.result_src_d  = x.result_src;
        bus.alu_control_d = x.alu_control;
    endtask

    task automatic wb(input logic we, input logic [REG_AW-1:0] a, input logic [XLEN-1:0] v);
        bus.reg_write_w = we;
        bus.rd_w        = a;
        bus.result_w    = v;
    endtask

    task automatic ctl(input logic st, input logic fl);
        bus.stall_e = st;
        bus.flush_e = fl;
    endtask

    function automatic slot_t observe();
        slot_t o;
        o.valid       = bus.valid_e;
        o.pc          = bus.pc_e;
        o.pc_plus4    = bus.pc_plus4_e;
        o.rd1         = bus.rd1_e;
        o.rd2         = bus.rd2_e;
        o.rs1         = bus.rs1_e;
        o.rs2         = bus.rs2_e;
        o.rd          = bus.rd_e;
        o.imm         = bus.imm_e;
        o.reg_write   = bus.reg_write_e;
        o.mem_write   = bus.mem_write_e;
        o.alu_src     = bus.alu_src_e;
        o.branch      = bus.branch_e;
        o.jump        = bus.jump_e;
        o.result_src  = bus.result_src_e;
        o.alu_control = bus.alu_control_e;
        return o;
    endfunction

    function automatic slot_t rand_slot();
        slot_t r;
        r.valid       = 1'b1;
        r.pc          = $urandom & 32'hFFFF_FFFC;
        r.pc_plus4    = r.pc + 32'd4;
        r.rd1         = $urandom;
        r.rd2         = $urandom;
        r.rs1         = REG_AW'($urandom);
        r.rs2         = REG_AW'($urandom);
        r.rd          = REG_AW'($urandom);
        r.imm         = $urandom;
        r.reg_write   = 1'($urandom);
        r.mem_write   = 1'($urandom);
        r.alu_src     = 1'($urandom);
        r.branch      = 1'($urandom);
        r.jump        = 1'($urandom);
        r.result_src  = 2'($urandom);
        r.alu_control = ALUC_W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        ctl(0, 0);
        wb(0, '0, '0);
        s = rand_slot();
        drive(s);
        sb.push_back('0);
        repeat (2) @(posedge clk);
        #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_hold got=%h want=%h", got, want); end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('0);
        #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_release got=%h want=%h", got, want); end
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL reset_first_load got=%h want=%h", got, want); end
    endtask

    task automatic test_load();
        @(negedge clk);
        s = '0;
        s.valid = 1'b1; s.pc = 32'h0000_1000; s.pc_plus4 = 32'h0000_1004;
        s.rd1 = 32'h1111_1111; s.rd2 = 32'h2222_2222;
        s.rs1 = 5'd3; s.rs2 = 5'd4; s.rd = 5'd5; s.imm = 32'hFFFF_FFF0;
        s.reg_write = 1'b1; s.alu_control = 3'b010; s.result_src = 2'b01;
        drive(s);
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL normal_load got=%h want=%h", got, want); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        s = rand_slot(); s.rs1 = 5'd3; s.rs2 = 5'd3; s.rd1 = '0; s.rd2 = '0;
        drive(s); wb(1, 5'd3, 32'hBABA_BABA);
        want = s; want.rd1 = 32'hBABA_BABA; want.rd2 = 32'hBABA_BABA;
        sb.push_back(want);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL bypass_both got=%h want=%h", got, want); end

        @(negedge clk);
        s = rand_slot(); s.rs1 = 5'd0; s.rs2 = 5'd9; s.rd1 = 32'h5; s.rd2 = 32'h6;
        drive(s); wb(1, 5'd0, 32'hBABA_BABA);
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL bypass_x0 got=%h want=%h", got, want); end

        @(negedge clk);
        s = rand_slot(); s.rs1 = 5'd8; s.rs2 = 5'd12;
        drive(s); wb(1, 5'd12, 32'h0000_CAFE);
        want = s; want.rd2 = 32'h0000_CAFE;
        sb.push_back(want);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL bypass_rs2_only got=%h want=%h", got, want); end

        @(negedge clk);
        s = rand_slot(); s.rs1 = 5'd12; s.rs2 = 5'd12;
        drive(s); wb(0, 5'd12, 32'h0000_CAFE);
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL bypass_we_off got=%h want=%h", got, want); end
    endtask

    task automatic test_stall_refresh();
        @(negedge clk);
        ctl(0, 0); wb(0, '0, '0);
        s = rand_slot(); s.rs1 = 5'd4; s.rd1 = 32'hA; s.rs2 = 5'd7; s.rd2 = 32'hB;
        drive(s);
        held = s;
        sb.push_back(held);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL stall_preload got=%h want=%h", got, want); end

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ctl(1, 0);
            drive(rand_slot());
            if (c == 1) begin
                wb(1, 5'd4, 32'hBABA_BABA);
                held.rd1 = 32'hBABA_BABA;
            end else if (c == 2) begin
                wb(1, 5'd7, 32'h7777_0000);
                held.rd2 = 32'h7777_0000;
            end else begin
                wb(0, 5'd4, 32'hDEAD_BEEF);
            end
            sb.push_back(held);
            @(posedge clk); #1;
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin failures++; $display("FAIL stall_cycle%0d got=%h want=%h", c, got, want); end
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        ctl(1, 1); wb(1, 5'd4, 32'h1234_5678);
        drive(rand_slot());
        sb.push_back('0);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL flush_beats_stall got=%h want=%h", got, want); end

        @(negedge clk);
        ctl(0, 0); wb(0, '0, '0);
        s = rand_slot(); drive(s);
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL flush_then_load got=%h want=%h", got, want); end

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            ctl(0, 1); drive(rand_slot());
            sb.push_back('0);
            @(posedge clk); #1;
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin failures++; $display("FAIL flush_run%0d got=%h want=%h", c, got, want); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ctl(0, 0); wb(0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            s = rand_slot();
            s.pc = 32'h0000_2000 + 32'(i * 4);
            drive(s);
            sb.push_back(s);
            @(posedge clk); #1;
            want = sb.pop_front(); got = observe(); checks++;
            if (got !== want) begin failures++; $display("FAIL b2b_%0d got=%h want=%h", i, got, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_stall();
        s = rand_slot(); drive(s);
        sb.push_back(s);
        @(posedge clk); #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL mid_reset_preload got=%h want=%h", got, want); end
        @(negedge clk);
        ctl(1, 0);
        #2 rst = 1'b0;
        sb.push_back('0);
        #1;
        want = sb.pop_front(); got = observe(); checks++;
        if (got !== want) begin failures++; $display("FAIL mid_stall_reset got=%h want=%h", got, want); end
        @(negedge clk);
        ctl(0, 0);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load();
        test_bypass();
        test_stall_refresh();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage register for the 32-bit 5-stage RISC-V pipeline. It sits directly downstream of the register file. It captures RD1/RD2, register addresses, immediate, PC values and decode control at the end of decode, and presents them to execute. A writeback bypass covers same-cycle register-file write/read collisions. Stall (hold) and flush (bubble insertion) let the hazard unit control it.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
ALUC_W, 3, ALU control field width

Ports:
clk  in  1  pipeline clock, rising-edge active
rst  in  1  asynchronous reset, active-low (0 = reset)
stall_e  in  1  hold current contents
flush_e  in  1  load a bubble
valid_d  in  1  decode slot holds a real instruction
pc_d  in  XLEN  PC of decode instruction
pc_plus4_d  in  XLEN  PC+4 of decode instruction
rd1_d  in  XLEN  register file RD1
rd2_d  in  XLEN  register file RD2
rs1_d  in  REG_AW  source 1 address (A1)
rs2_d  in  REG_AW  source 2 address (A2)
rd_d  in  REG_AW  destination address
imm_d  in  XLEN  sign-extended immediate
reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d  in  1 each  decode control
result_src_d  in  2  result mux select
alu_control_d  in  ALUC_W  ALU operation
reg_write_w  in  1  writeback write enable (register file WE)
rd_w  in  REG_AW  writeback address (A3)
result_w  in  XLEN  writeback data (WD)
valid_e  out  1  execute slot valid
Outputs pc_e through alu_control_e mirror each *_d input above, with the same widths.

Behaviour:
- Reset (rst=0, asynchronous): every output goes to 0 immediately, independent of clk. This is a bubble: valid_e=0, all control=0. It holds until the first rising edge after rst returns to 1.
- Each rising edge applies the first matching rule, in this priority order:
  1. flush_e=1: load bubble; all outputs 0. Flush beats stall.
  2. stall_e=1: hold all fields except the hold-refresh described below.
  3. otherwise: load all *_d inputs into the *_e outputs; latency is 1 cycle.
- Bypass on load:
  - rd1_e takes result_w when reg_write_w=1 and rd_w==rs1_d and rd_w!=0. Otherwise it takes rd1_d.
  - rd2_e uses the same rule with rs2_d.
  - This bypass is independent of the register file's internal write timing.
- Hold-refresh during stall:
  - If reg_write_w=1, rd_w!=0 and rd_w==rs1_e, then rd1_e takes result_w.
  - rd2_e follows the same rule with rs2_e.
  - This prevents stale operands after a long stall.
- x0 rule: an address of 0 never bypasses or refreshes. A 0 read from x0 passes through as supplied by rd1_d/rd2_d.
- Bypass vs valid: the bypass and refresh paths ignore valid_d/valid_e and are purely address-based. A bubble carries zero addresses, so it never matches.
- Control fields are not gated by valid_d; upstream supplies zeros for invalid slots. Flush forces zeros regardless.
- Flush asserted for N consecutive cycles yields N consecutive bubbles.
- rst asserted mid-stall or mid-flush wins immediately.
- No combinational path from any input to any output.

Test Plan:
1. Reset: hold rst=0 with arbitrary inputs; release rst between edges -> all outputs 0 immediately; first edge after release loads inputs.
2. Normal load: rd1_d=0x11111111, rd2_d=0x22222222, rs1_d=3, rs2_d=4, rd_d=5, alu_control_d=3'b010, reg_write_d=1, valid_d=1 -> one cycle later all *_e match the inputs.
3. WB bypass: rs1_d=3, rs2_d=3, reg_write_w=1, rd_w=3, result_w=0xBABABABA, rd1_d=rd2_d=0 -> rd1_e=rd2_e=0xBABABABA. Repeat with rd_w=0, rs1_d=0 -> rd1_e=rd1_d.
4. Stall with refresh: load rs1=4 (rd1=0xA); stall 3 cycles; on cycle 2 pulse reg_write_w=1, rd_w=4, result_w=0xBABABABA -> rd1_e=0xBABABABA, other fields unchanged, valid_e held at 1.
5. Flush priority: stall_e=1 and flush_e=1 on the same edge with a valid instruction loaded -> all outputs 0, valid_e=0. Next edge with both low -> new input loaded.
6. Back-to-back: a distinct instruction each cycle for 4 cycles with reg_write_w=0 -> outputs track inputs with exactly 1-cycle delay, no drops or duplicates.
